// File: rtl/rr_port_arbiter_pkg.sv
// Shared types and limits for the round-robin port arbiter.
package rr_arb_pkg;

    localparam int unsigned RR_MAX_REQ = 16;
    localparam int unsigned RR_IDX_W   = $clog2(RR_MAX_REQ);

    typedef logic [RR_IDX_W-1:0] rr_idx_t;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } rr_state_e;

endpackage

// File: rtl/rr_port_arbiter_if.sv
// Requester-side and consumer-side handshake bundle of the round-robin port arbiter.
interface rr_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned REQ_CNT    = 4
);
    localparam int unsigned IDX_W = $clog2(REQ_CNT);

    logic [REQ_CNT-1:0][DATA_WIDTH-1:0] in_data;
    logic [REQ_CNT-1:0]                 in_valid;
    logic [REQ_CNT-1:0]                 in_ready;
    logic [DATA_WIDTH-1:0]              out_data;
    logic                               out_valid;
    logic                               out_ready;
    logic [IDX_W-1:0]                   out_grant;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_grant
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_grant
    );

endinterface

// File: rtl/rr_port_arbiter_pick.sv
// Combinational rotating priority picker: first set req bit at or after ptr, wrapping.
module rr_priority_pick
    import rr_arb_pkg::*;
#(
    parameter int unsigned REQ_CNT = 4
) (
    input  logic [REQ_CNT-1:0] req,
    input  rr_idx_t            ptr,
    output logic               gnt_valid,
    output rr_idx_t            gnt_idx
);
    localparam int unsigned IDX_W = $clog2(REQ_CNT);

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        int j;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int i = int'(REQ_CNT) - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= int'(REQ_CNT)) j = j - int'(REQ_CNT);
            if (req[IDX_W'(j)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = RR_IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter sharing one registered output port between valid/ready requesters.
// Optional burst lock is compiled in with RR_PORT_ARBITER_BURST_EN.
module rr_port_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned REQ_CNT    = 4,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    rr_port_arbiter_if.slave port
);
    localparam int unsigned IDX_W = $clog2(REQ_CNT);
    typedef logic [IDX_W-1:0] idx_t;

    if (REQ_CNT < 2 || REQ_CNT > RR_MAX_REQ || BURST_LEN < 1 || BURST_LEN > RR_MAX_REQ) begin : g_bad_cfg
        $error("rr_port_arbiter: REQ_CNT or BURST_LEN out of range");
    end

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    idx_t                  out_grant_q, out_grant_d;
    idx_t                  ptr_q, ptr_d;
    logic                  load_c, xfer_c, gnt_valid_c;
    logic [REQ_CNT-1:0]    req_c;
    rr_idx_t               gnt_idx_c;
    idx_t                  gnt_c;

    function automatic idx_t nxt(input idx_t i);
        return (int'(i) == int'(REQ_CNT) - 1) ? '0 : i + IDX_W'(1);
    endfunction

    assign load_c = !out_valid_q || port.out_ready;

    rr_priority_pick #(.REQ_CNT(REQ_CNT)) u_pick (
        .req      (req_c),
        .ptr      (RR_IDX_W'(ptr_q)),
        .gnt_valid(gnt_valid_c),
        .gnt_idx  (gnt_idx_c)
    );

    assign gnt_c         = IDX_W'(gnt_idx_c);
    assign xfer_c        = load_c && gnt_valid_c && !rst;
    assign port.in_ready = xfer_c ? (REQ_CNT'(1) << gnt_c) : '0;

    // Output register: load on a grant, drain to empty when nothing is offered.
    always_comb begin
        out_data_d  = out_data_q;
        out_grant_d = out_grant_q;
        out_valid_d = out_valid_q;
        if (xfer_c) begin
            out_data_d  = port.in_data[gnt_c];
            out_grant_d = gnt_c;
            out_valid_d = 1'b1;
        end else if (load_c) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef RR_PORT_ARBITER_BURST_EN
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    rr_state_e          state_q, state_d;
    idx_t               lk_q, lk_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REQ_CNT-1:0] lk_mask_c;

    assign lk_mask_c = REQ_CNT'(1) << lk_q;
    assign req_c     = (state_q == LOCK) ? (port.in_valid & lk_mask_c) : port.in_valid;

    // While locked the pointer stays put; it resumes just past the locked requester.
    always_comb begin
        state_d = state_q;
        lk_d    = lk_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB: begin
                if (xfer_c) begin
                    if (BURST_LEN > 1) begin
                        state_d = LOCK;
                        lk_d    = gnt_c;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        ptr_d = nxt(gnt_c);
                    end
                end
            end
            LOCK: begin
                if (load_c) begin
                    if (!port.in_valid[lk_q]) begin
                        state_d = ARB;
                        cnt_d   = '0;
                        ptr_d   = nxt(lk_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == CNT_W'(BURST_LEN)) begin
                            state_d = ARB;
                            cnt_d   = '0;
                            ptr_d   = nxt(lk_q);
                        end
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            lk_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lk_q    <= lk_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign req_c = port.in_valid;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer_c) ptr_d = nxt(gnt_c);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_grant_q <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_grant_q <= out_grant_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign port.out_data  = out_data_q;
    assign port.out_grant = out_grant_q;
    assign port.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Self-checking bench for rr_port_arbiter against a behavioural round-robin model.
module tb_rr_port_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned RC = 4;
    localparam int unsigned BL = 3;
`ifdef RR_PORT_ARBITER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_port_arbiter_if #(.DATA_WIDTH(DW), .REQ_CNT(RC)) bus ();

    rr_port_arbiter #(.DATA_WIDTH(DW), .REQ_CNT(RC), .BURST_LEN(BL)) dut (
        .clk (clk),
        .rst (rst),
        .port(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: what the output port should hold and whose turn is next.
    int m_ptr, m_grant, m_data, m_lk, m_cnt;
    bit m_valid, m_lock;

    task automatic model_reset();
        m_ptr = 0; m_grant = 0; m_data = 0; m_valid = 0; m_lock = 0; m_lk = 0; m_cnt = 0;
    endtask

    function automatic int model_pick();
        int idx;
        if (m_lock) return bus.in_valid[2'(m_lk)] ? m_lk : -1;
        for (int k = 0; k < int'(RC); k++) begin
            idx = (m_ptr + k) % int'(RC);
            if (bus.in_valid[2'(idx)]) return idx;
        end
        return -1;
    endfunction

    // Advance one clock; returns the expected and observed in_ready sampled before the edge.
    task automatic cycle(output logic [RC-1:0] exp_rdy, output logic [RC-1:0] got_rdy);
        bit load;
        int g, d;
        #1;
        load    = !m_valid || bus.out_ready;
        g       = load ? model_pick() : -1;
        exp_rdy = (g >= 0) ? RC'(1 << g) : '0;
        got_rdy = bus.in_ready;
        d       = (g >= 0) ? int'(bus.in_data[2'(g)]) : 0;
        @(posedge clk);
        #1;
        if (load) begin
            if (g >= 0) begin
                m_data = d; m_grant = g; m_valid = 1'b1;
                if (!BURST) m_ptr = (g + 1) % int'(RC);
                else if (!m_lock) begin
                    if (BL > 1) begin m_lock = 1'b1; m_lk = g; m_cnt = 1; end
                    else m_ptr = (g + 1) % int'(RC);
                end else begin
                    m_cnt++;
                    if (m_cnt == int'(BL)) begin m_lock = 1'b0; m_ptr = (m_lk + 1) % int'(RC); end
                end
            end else begin
                m_valid = 1'b0;
                if (m_lock) begin m_lock = 1'b0; m_ptr = (m_lk + 1) % int'(RC); end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = '0;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [RC-1:0] e, g;
        rst = 1'b1;
        repeat (3) begin
            bus.in_valid  = 4'($urandom);
            bus.in_data   = 32'($urandom);
            bus.out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            n_cmp++; if (bus.in_ready !== 4'b0) begin n_bad++; $display("FAIL rst_in_ready got=%b want=0000", bus.in_ready); end
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL rst_out_data got=%h want=00", bus.out_data); end
        n_cmp++; if (bus.out_grant !== 2'd0) begin n_bad++; $display("FAIL rst_out_grant got=%0d want=0", bus.out_grant); end
        do_reset();
        bus.in_valid   = 4'b0100;
        bus.in_data[2] = 8'h5A;
        bus.out_ready  = 1'b1;
        cycle(e, g);
        n_cmp++; if (g !== 4'b0100) begin n_bad++; $display("FAIL first_in_ready got=%b want=0100", g); end
        n_cmp++; if (bus.out_data !== 8'h5A) begin n_bad++; $display("FAIL first_out_data got=%h want=5a", bus.out_data); end
        n_cmp++; if (bus.out_grant !== 2'd2) begin n_bad++; $display("FAIL first_out_grant got=%0d want=2", bus.out_grant); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL first_out_valid got=%b want=1", bus.out_valid); end
    endtask

    task automatic test_fairness();
        logic [RC-1:0] e, g;
        do_reset();
        bus.in_valid  = 4'b1111;
        bus.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(e, g);
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL fair_rdy[%0d] got=%b want=%b", i, g, e); end
            n_cmp++; if (bus.out_data !== 8'(m_data)) begin n_bad++; $display("FAIL fair_data[%0d] got=%h want=%h", i, bus.out_data, 8'(m_data)); end
`ifndef RR_PORT_ARBITER_BURST_EN
            n_cmp++; if (bus.out_data !== 8'(8'h10 + i % 4)) begin n_bad++; $display("FAIL fair_seq[%0d] got=%h want=%h", i, bus.out_data, 8'(8'h10 + i % 4)); end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [RC-1:0] e, g;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(e, g);
            n_cmp++; if (g !== 4'b0000) begin n_bad++; $display("FAIL bp_rdy[%0d] got=%b want=0000", i, g); end
            n_cmp++; if ({bus.out_valid, bus.out_data, bus.out_grant} !== {1'b1, 8'(m_data), 2'(m_grant)})
                begin n_bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d want=1/%h/%0d", i, bus.out_valid, bus.out_data, bus.out_grant, 8'(m_data), m_grant); end
        end
        bus.out_ready = 1'b1;
        cycle(e, g);
        n_cmp++; if (g !== e) begin n_bad++; $display("FAIL bp_release_rdy got=%b want=%b", g, e); end
        n_cmp++; if (bus.out_grant !== 2'(m_grant)) begin n_bad++; $display("FAIL bp_release_grant got=%0d want=%0d", bus.out_grant, m_grant); end
    endtask

    task automatic test_sparse();
        logic [RC-1:0] e, g;
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        bus.in_valid  = 4'b0001;
        cycle(e, g);
        bus.in_valid = 4'b1000;
        cycle(e, g);
        n_cmp++; if ({bus.out_valid, bus.out_grant} !== {m_valid, 2'(m_grant)})
            begin n_bad++; $display("FAIL skip_to_3 got=%b/%0d want=%b/%0d", bus.out_valid, bus.out_grant, m_valid, m_grant); end
`ifndef RR_PORT_ARBITER_BURST_EN
        n_cmp++; if (bus.out_data !== 8'hD3) begin n_bad++; $display("FAIL skip_to_3_data got=%h want=d3", bus.out_data); end
`endif
        bus.in_valid = 4'b0001;
        cycle(e, g);
        n_cmp++; if (g !== e) begin n_bad++; $display("FAIL wrap_rdy got=%b want=%b", g, e); end
        n_cmp++; if ({bus.out_valid, bus.out_grant} !== {1'b1, 2'd0})
            begin n_bad++; $display("FAIL wrap_to_0 got=%b/%0d want=1/0", bus.out_valid, bus.out_grant); end
    endtask

    task automatic test_reset_mid();
        logic [RC-1:0] e, g;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        cycle(e, g);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid got=%b want=0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 4'b0) begin n_bad++; $display("FAIL async_rst_rdy got=%b want=0000", bus.in_ready); end
        #1;
        rst = 1'b0;
        model_reset();
        bus.in_valid = 4'b0110;
        cycle(e, g);
        n_cmp++; if ({bus.out_valid, bus.out_grant} !== {1'b1, 2'd1})
            begin n_bad++; $display("FAIL post_rst_grant got=%b/%0d want=1/1", bus.out_valid, bus.out_grant); end
    endtask

    task automatic test_random();
        logic [RC-1:0] e, g;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 4'($urandom);
            bus.in_data   = 32'($urandom);
            bus.out_ready = ($urandom_range(3) != 0);
            cycle(e, g);
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL rand_rdy[%0d] got=%b want=%b", i, g, e); end
            n_cmp++; if (bus.out_valid !== m_valid || (m_valid && {bus.out_data, bus.out_grant} !== {8'(m_data), 2'(m_grant)}))
                begin n_bad++; $display("FAIL rand_out[%0d] got=%b/%h/%0d want=%b/%h/%0d", i, bus.out_valid, bus.out_data, bus.out_grant, m_valid, 8'(m_data), m_grant); end
        end
    endtask

`ifdef RR_PORT_ARBITER_BURST_EN
    task automatic test_burst();
        logic [RC-1:0] e, g;
        logic [1:0] exp_seq [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        bit got_one;
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
        bus.in_valid  = 4'b0011;
        for (int i = 0; i < 7; i++) begin
            cycle(e, g);
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL burst_rdy[%0d] got=%b want=%b", i, g, e); end
            n_cmp++; if ({bus.out_valid, bus.out_grant} !== {1'b1, exp_seq[i]})
                begin n_bad++; $display("FAIL burst_seq[%0d] got=%b/%0d want=1/%0d", i, bus.out_valid, bus.out_grant, exp_seq[i]); end
        end
        do_reset();
        bus.in_valid = 4'b0011;
        cycle(e, g);
        bus.in_valid = 4'b0010;
        got_one = 1'b0;
        for (int i = 0; i < 4 && !got_one; i++) begin
            cycle(e, g);
            n_cmp++; if (bus.out_valid !== m_valid) begin n_bad++; $display("FAIL drop_valid[%0d] got=%b want=%b", i, bus.out_valid, m_valid); end
            if (bus.out_valid && bus.out_grant == 2'd1) got_one = 1'b1;
        end
        n_cmp++; if (!got_one) begin n_bad++; $display("FAIL drop_pass_to_1 got=none want=grant 1 within 4 cycles"); end
    endtask
`endif

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_fairness();
        test_backpressure();
        test_sparse();
        test_reset_mid();
        test_random();
`ifdef RR_PORT_ARBITER_BURST_EN
        test_burst();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
